arm_flag_branch_unit: RTL and testbench
=======================================

Name: arm_flag_branch_unit

Overview:
Consumer side of the ALU result/flag interface.
- Captures the ALU's result and Zero/Overflow/Carryout outputs into an architectural NZCV register on flag-setting instructions (ADDS, SUBS, ANDS).
- Evaluates LEGv8 branch decisions (B.cond, CBZ, CBNZ, B) against those flags or a register operand.
- Returns registered branch outcomes over a valid/ready handshake to the fetch/PC logic.

Parameters:
TAG_W, 4, width of the branch request tag echoed with each outcome
FORWARD, 1, 1 = a branch accepted in the same cycle as a flag write sees the new flags; 0 = it sees the old flags
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU outputs valid this cycle
alu_set_flags  input  1  current ALU instruction updates NZCV
alu_result  input  64  ALU result; bit 63 supplies N
alu_zero  input  1  ALU Zero output
alu_overflow  input  1  ALU Overflow output
alu_carryout  input  1  ALU Carryout output
br_valid  input  1  branch request present
br_ready  output  1  unit can accept a branch request this cycle
br_type  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional)
br_cond  input  4  LEGv8 condition code for B.cond
br_operand  input  64  register value tested by CBZ/CBNZ
br_tag  input  TAG_W  request identifier
out_valid  output  1  branch outcome present
out_ready  input  1  consumer accepts outcome
out_taken  output  1  branch taken
out_tag  output  TAG_W  tag of the evaluated request
flags  output  4  current NZCV, bit3 = N, bit0 = V
br_count  output  CNT_W  accepted branch requests, wraps
taken_count  output  CNT_W  accepted requests evaluated taken, wraps

Behaviour:
Timing and reset:
- Single clock domain; all state updates on the rising edge of clk.
- reset (synchronous, active-high) clears: flags, out_valid, out_taken, out_tag, br_count, taken_count. Reset wins over every simultaneous event; a pending outcome is discarded.

Flag write:
- Occurs when alu_valid && alu_set_flags.
- Next NZCV = {alu_result[63], alu_zero, alu_carryout, alu_overflow}.
- Flag writes never stall and are independent of branch backpressure.
- alu_valid with alu_set_flags = 0 leaves flags unchanged.

Handshake:
- br_ready = !out_valid || out_ready, combinational.
- A request is accepted when br_valid && br_ready.
- Outcome appears on out_* the next cycle (latency 1).
- Output slot is single-entry:
  - out_valid && !out_ready: out_valid, out_taken and out_tag hold stable.
  - out_valid && out_ready with no new accept: out_valid drops to 0.
  - Accept in the same cycle as a drain gives back-to-back outcomes, full throughput.

Evaluation flags (F):
- FORWARD = 1 and a flag write occurs in the accept cycle: F = incoming NZCV.
- Otherwise F = registered flags.

Taken rules by br_type:
- B: always taken.
- CBZ: taken iff br_operand == 0.
- CBNZ: taken iff br_operand != 0.
- B.cond: per br_cond, below.

B.cond condition codes:
- 0 EQ: Z
- 1 NE: !Z
- 2 HS: C
- 3 LO: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C && !Z
- 9 LS: !(C && !Z)
- 10 GE: N == V
- 11 LT: N != V
- 12 GT: !Z && N == V
- 13 LE: !(!Z && N == V)
- 14 AL: 1
- 15 NV: 1

Counters:
- br_count increments on every accept.
- taken_count increments on accepts evaluated taken.
- Both wrap from all-ones to 0.

Other rules:
- br_type, br_cond, br_operand and br_tag are ignored when there is no accept.
- CBZ/CBNZ never read flags.

Test Plan:
- Reset, then idle 3 cycles: flags = 0000, out_valid = 0, br_ready = 1, both counters = 0.
- Flag write with alu_result = 0x8000_0000_0000_0000, Z = 0, C = 1, V = 0; next cycle B.cond with cond = 11 (LT), tag 3: flags = 1010, out_taken = 1, out_tag = 3, one cycle after accept.
- FORWARD = 1: flags = 0000; flag write Z = 1 in the same cycle as B.cond EQ -> out_taken = 1. Repeat with FORWARD = 0 -> out_taken = 0.
- Backpressure: out_ready = 0 for 4 cycles with br_valid held -> br_ready = 0, out_* stable, br_count += 1 only. Raise out_ready -> second outcome appears the next cycle.
- CBZ with operand 0 then CBNZ with operand 0x1, back-to-back with out_ready = 1: outcomes taken, taken on consecutive cycles; taken_count = 2.
- reset asserted while out_valid = 1 and out_ready = 0: next cycle out_valid = 0, flags = 0000, counters = 0.

Source files
------------

// File: rtl/arm_flag_branch_unit.sv
// Purpose: NZCV flag register fed by the ALU plus a LEGv8 branch evaluator (B.cond, CBZ, CBNZ, B).
// Latency: outcome is registered; it appears on out_* one cycle after the request is accepted.
// Backpressure: single-entry output slot, br_ready = !out_valid || out_ready; flag writes never stall.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   alu_valid/alu_set_flags    a flag write happens when both are high
//   alu_result/zero/overflow/carryout   ALU outputs; alu_result[63] supplies N
//   br_valid/br_ready          branch request handshake
//   br_type/br_cond/br_operand/br_tag   request payload
//   out_valid/out_ready        outcome handshake; out_taken/out_tag are the outcome payload
//   flags                      architectural NZCV (bit3 = N, bit0 = V)
//   br_count/taken_count       wrapping statistics counters
module arm_flag_branch_unit #(
    parameter int TAG_W   = 4,
    parameter bit FORWARD = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic             alu_set_flags,
    input  logic [63:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carryout,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic [63:0]      br_operand,
    input  logic [TAG_W-1:0] br_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [1:0] BT_COND = 2'b00;
    localparam logic [1:0] BT_CBZ  = 2'b01;
    localparam logic [1:0] BT_CBNZ = 2'b10;
    localparam logic [1:0] BT_B    = 2'b11;

    logic       flag_wr;
    logic [3:0] flags_new;
    logic [3:0] eval_flags;
    logic       accept;
    logic       cond_true;
    logic       br_taken;
    logic       f_n, f_z, f_c, f_v;

    // Only the sign bit of the ALU result feeds the flags; the rest is
    // reduced into a deliberately unused net.
    logic unused_result_bits;
    assign unused_result_bits = ^alu_result[62:0];

    assign flag_wr   = alu_valid && alu_set_flags;
    assign flags_new = {alu_result[63], alu_zero, alu_carryout, alu_overflow};

    // With forwarding, a branch accepted alongside a flag write sees the
    // flags that instruction is producing rather than the stale register.
    assign eval_flags = (FORWARD && flag_wr) ? flags_new : flags;
    assign f_n = eval_flags[3];
    assign f_z = eval_flags[2];
    assign f_c = eval_flags[1];
    assign f_v = eval_flags[0];

    assign br_ready = !out_valid || out_ready;
    assign accept   = br_valid && br_ready;

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            4'd0:    cond_true = f_z;
            4'd1:    cond_true = !f_z;
            4'd2:    cond_true = f_c;
            4'd3:    cond_true = !f_c;
            4'd4:    cond_true = f_n;
            4'd5:    cond_true = !f_n;
            4'd6:    cond_true = f_v;
            4'd7:    cond_true = !f_v;
            4'd8:    cond_true = f_c && !f_z;
            4'd9:    cond_true = !(f_c && !f_z);
            4'd10:   cond_true = (f_n == f_v);
            4'd11:   cond_true = (f_n != f_v);
            4'd12:   cond_true = !f_z && (f_n == f_v);
            4'd13:   cond_true = !(!f_z && (f_n == f_v));
            default: cond_true = 1'b1;  // AL and NV both execute
        endcase
    end

    // CBZ/CBNZ look only at the register operand, never at the flags.
    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            BT_COND: br_taken = cond_true;
            BT_CBZ:  br_taken = (br_operand == 64'd0);
            BT_CBNZ: br_taken = (br_operand != 64'd0);
            BT_B:    br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags       <= 4'b0000;
            out_valid   <= 1'b0;
            out_taken   <= 1'b0;
            out_tag     <= '0;
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (flag_wr) begin
                flags <= flags_new;
            end
            if (accept) begin
                out_valid   <= 1'b1;
                out_taken   <= br_taken;
                out_tag     <= br_tag;
                br_count    <= br_count + CNT_W'(1);
                taken_count <= taken_count + CNT_W'(br_taken);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arm_flag_branch_unit.sv
// Purpose: directed self-checking bench for arm_flag_branch_unit.
// Latency: drives just after each rising edge and checks registered outputs there.
// Backpressure: exercises a stalled output slot and its release.
//
// Instance a: FORWARD = 1, 32-bit counters.  Instance b: FORWARD = 0, 4-bit
// counters so wrap-around is reached with a handful of branches.
module tb_arm_flag_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_set_flags = 1'b0;
    logic [63:0] alu_result = 64'd0;
    logic        alu_zero = 1'b0;
    logic        alu_overflow = 1'b0;
    logic        alu_carryout = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic [3:0]  br_cond = 4'd0;
    logic [63:0] br_operand = 64'd0;
    logic [3:0]  br_tag = 4'd0;
    logic        out_ready = 1'b1;

    logic        a_br_ready, a_out_valid, a_out_taken;
    logic [3:0]  a_out_tag, a_flags;
    logic [31:0] a_br_count, a_taken_count;
    logic        b_br_ready, b_out_valid, b_out_taken;
    logic [3:0]  b_out_tag, b_flags;
    logic [3:0]  b_br_count, b_taken_count;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_br = 0;
    int exp_tk = 0;
    int exp_tk_b = 0;

    always #5 clk = ~clk;

    arm_flag_branch_unit #(.TAG_W(4), .FORWARD(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_set_flags(alu_set_flags), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
        .br_valid(br_valid), .br_ready(a_br_ready), .br_type(br_type), .br_cond(br_cond),
        .br_operand(br_operand), .br_tag(br_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_taken(a_out_taken), .out_tag(a_out_tag),
        .flags(a_flags), .br_count(a_br_count), .taken_count(a_taken_count)
    );

    arm_flag_branch_unit #(.TAG_W(4), .FORWARD(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_set_flags(alu_set_flags), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
        .br_valid(br_valid), .br_ready(b_br_ready), .br_type(br_type), .br_cond(br_cond),
        .br_operand(br_operand), .br_tag(br_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_taken(b_out_taken), .out_tag(b_out_tag),
        .flags(b_flags), .br_count(b_br_count), .taken_count(b_taken_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flag_write(input logic n, input logic z, input logic c, input logic v);
        alu_valid     = 1'b1;
        alu_set_flags = 1'b1;
        alu_result    = n ? 64'h8000_0000_0000_0000 : 64'h0000_0000_0000_0042;
        alu_zero      = z;
        alu_carryout  = c;
        alu_overflow  = v;
    endtask

    task automatic alu_idle();
        alu_valid     = 1'b0;
        alu_set_flags = 1'b0;
    endtask

    task automatic req(input logic [1:0] t, input logic [3:0] c, input logic [63:0] op, input logic [3:0] tg);
        br_valid   = 1'b1;
        br_type    = t;
        br_cond    = c;
        br_operand = op;
        br_tag     = tg;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".a_br_count"},    64'(a_br_count),    64'(exp_br));
        check({tag, ".a_taken_count"}, 64'(a_taken_count), 64'(exp_tk));
        check({tag, ".b_br_count"},    64'(b_br_count),    64'(exp_br % 16));
        check({tag, ".b_taken_count"}, 64'(b_taken_count), 64'(exp_tk_b % 16));
    endtask

    // Bit i = expected B.cond outcome for condition code i under a given NZCV.
    logic [15:0] exp_1010;
    logic [15:0] exp_0101;

    initial begin
        exp_1010 = 16'hE996;
        exp_0101 = 16'hEA69;

        // Reset, then idle
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        check("rst.flags",     64'(a_flags),     64'h0);
        check("rst.out_valid", 64'(a_out_valid), 64'h0);
        check("rst.br_ready",  64'(a_br_ready),  64'h1);
        check_counts("rst");

        // NZCV = 1010 then B.cond LT, tag 3
        flag_write(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        alu_idle();
        check("fw1.flags_a", 64'(a_flags), 64'hA);
        check("fw1.flags_b", 64'(b_flags), 64'hA);
        req(2'b00, 4'd11, 64'd0, 4'd3);
        step();
        br_valid = 1'b0;
        exp_br++; exp_tk++; exp_tk_b++;
        check("lt.out_valid", 64'(a_out_valid), 64'h1);
        check("lt.out_taken", 64'(a_out_taken), 64'h1);
        check("lt.out_tag",   64'(a_out_tag),   64'h3);
        check_counts("lt");
        step();
        check("lt.drain", 64'(a_out_valid), 64'h0);

        // All 16 conditions back-to-back under NZCV = 1010
        for (int i = 0; i < 16; i++) begin
            req(2'b00, 4'(i), 64'd0, 4'(i));
            step();
            exp_br++;
            if (exp_1010[i]) begin exp_tk++; exp_tk_b++; end
            check($sformatf("c1010[%0d].valid", i), 64'(a_out_valid), 64'h1);
            check($sformatf("c1010[%0d].taken", i), 64'(a_out_taken), 64'(exp_1010[i]));
            check($sformatf("c1010[%0d].tag",   i), 64'(a_out_tag),   64'(i));
        end
        br_valid = 1'b0;

        // NZCV = 0101, written while the last outcome drains
        flag_write(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        alu_idle();
        check("fw2.flags", 64'(a_flags), 64'h5);
        check("fw2.drain", 64'(a_out_valid), 64'h0);
        for (int i = 0; i < 16; i++) begin
            req(2'b00, 4'(i), 64'd0, 4'(15 - i));
            step();
            exp_br++;
            if (exp_0101[i]) begin exp_tk++; exp_tk_b++; end
            check($sformatf("c0101[%0d].taken", i), 64'(b_out_taken), 64'(exp_0101[i]));
            check($sformatf("c0101[%0d].tag",   i), 64'(b_out_tag),   64'(15 - i));
        end
        br_valid = 1'b0;
        check_counts("conds");

        // Forwarding: flags 0000, then write Z=1 alongside B.cond EQ
        flag_write(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("fwd.flags0", 64'(a_flags), 64'h0);
        flag_write(1'b0, 1'b1, 1'b0, 1'b0);
        req(2'b00, 4'd0, 64'd0, 4'd5);
        step();
        alu_idle();
        br_valid = 1'b0;
        exp_br++; exp_tk++;
        check("fwd.taken_fwd1", 64'(a_out_taken), 64'h1);
        check("fwd.taken_fwd0", 64'(b_out_taken), 64'h0);
        check("fwd.flags_a",    64'(a_flags),     64'h4);
        check("fwd.flags_b",    64'(b_flags),     64'h4);
        check_counts("fwd");
        step();

        // Backpressure: slot held for 4 cycles with a second request waiting
        out_ready = 1'b0;
        req(2'b11, 4'd0, 64'd0, 4'd7);
        step();
        exp_br++; exp_tk++; exp_tk_b++;
        req(2'b01, 4'd0, 64'd5, 4'd8);   // CBZ on nonzero: not taken
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp[%0d].br_ready", i), 64'(a_br_ready), 64'h0);
            check($sformatf("bp[%0d].out", i), {59'd0, a_out_valid, a_out_tag}, {59'd0, 1'b1, 4'd7});
            check($sformatf("bp[%0d].taken", i), 64'(a_out_taken), 64'h1);
            step();
        end
        check_counts("bp");
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(a_br_ready), 64'h1);
        step();
        br_valid = 1'b0;
        exp_br++;
        check("bp.second", {59'd0, a_out_valid, a_out_tag}, {59'd0, 1'b1, 4'd8});
        check("bp.second_taken", 64'(a_out_taken), 64'h0);
        check_counts("bp2");
        step();

        // CBZ 0 then CBNZ 1 back-to-back; then the not-taken forms
        req(2'b01, 4'd0, 64'd0, 4'd9);
        step();
        check("cbz0.taken", {62'd0, a_out_valid, a_out_taken}, 64'h3);
        req(2'b10, 4'd0, 64'h1, 4'd10);
        step();
        check("cbnz1.taken", {62'd0, a_out_valid, a_out_taken}, 64'h3);
        check("cbnz1.tag",   64'(a_out_tag), 64'hA);
        exp_br += 2; exp_tk += 2; exp_tk_b += 2;
        check_counts("cb");
        req(2'b10, 4'd0, 64'd0, 4'd11);
        step();
        check("cbnz0.taken", 64'(a_out_taken), 64'h0);
        req(2'b01, 4'd0, 64'h8000_0000_0000_0000, 4'd12);
        step();
        check("cbzneg.taken", 64'(a_out_taken), 64'h0);
        br_valid = 1'b0;
        exp_br += 2;
        check_counts("cbn");

        // Reset with an outcome stalled and a simultaneous flag write
        out_ready = 1'b0;
        req(2'b11, 4'd0, 64'd0, 4'd13);
        step();
        br_valid = 1'b0;
        check("prerst.out_valid", 64'(a_out_valid), 64'h1);
        reset = 1'b1;
        flag_write(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        alu_idle();
        out_ready = 1'b1;
        exp_br = 0; exp_tk = 0; exp_tk_b = 0;
        check("rst2.out_valid", 64'(a_out_valid), 64'h0);
        check("rst2.out_taken", 64'(a_out_taken), 64'h0);
        check("rst2.out_tag",   64'(a_out_tag),   64'h0);
        check("rst2.flags",     64'(a_flags),     64'h0);
        check_counts("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
